// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory port: access sizes, responder states, byte strobes.
package mips_mem_pkg;

   localparam logic [1:0] SIZE_BYTE    = 2'd0;
   localparam logic [1:0] SIZE_HALF    = 2'd1;
   localparam logic [1:0] SIZE_WORD    = 2'd2;
   localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } respState_t;

   typedef logic [3:0] strobe_t;

endpackage

// File: rtl/mem_wstrb_gen.sv
// Byte-lane write strobe and alignment check from access size and low address bits.
// Purely combinational; misaligned or illegal accesses yield an all-zero strobe.
module mem_wstrb_gen
   import mips_mem_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addrLo,
   output strobe_t    strobe,
   output logic       misaligned
);

   always_comb begin
      strobe     = '0;
      misaligned = 1'b0;
      case (size)
         SIZE_BYTE: strobe = strobe_t'(4'b0001 << addrLo);
         SIZE_HALF: begin
            if (addrLo[0]) misaligned = 1'b1;
            else           strobe     = strobe_t'(4'b0011 << {addrLo[1], 1'b0});
         end
         SIZE_WORD: begin
            if (|addrLo) misaligned = 1'b1;
            else         strobe     = 4'b1111;
         end
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_sram_responder.sv
// Single-outstanding sram-like data-memory slave; responds LATENCY cycles after accept.
// addr_ok is low while a request is in flight, so a new request waits until the response cycle.
module dmem_sram_responder
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        addr_err,
   output logic        busy
);

   localparam int         DEPTH    = 2 ** ADDR_W;
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   respState_t        state, nextState;
   logic [3:0]        cnt, cntNext;
   logic              accept;
   strobe_t           strobe;
   logic              misaligned;
   logic [ADDR_W-1:0] wordIdx, idxLat, rdIdx;
   logic              wrLat, errLat, respWr, respErr;
   logic [31:0]       ramWord, rdataReg;
   logic              errReg;
   logic              unusedAddrHi;

   assign wordIdx      = addr[ADDR_W+1:2];
   assign unusedAddrHi = ^addr[31:ADDR_W+2];

   mem_wstrb_gen uStrb (
      .size       (size),
      .addrLo     (addr[1:0]),
      .strobe     (strobe),
      .misaligned (misaligned)
   );

   assign addr_ok = rst && (state == IDLE || state == RESP);

   always_comb begin
      nextState = state;
      cntNext   = cnt;
      accept    = 1'b0;
      case (state)
         IDLE, RESP: begin
            if (req && addr_ok) begin
               accept    = 1'b1;
               nextState = (LATENCY == 1) ? RESP : WAIT;
               cntNext   = CNT_INIT;
            end else if (state == RESP) begin
               nextState = IDLE;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) nextState = RESP;
            else             cntNext   = cnt - 4'd1;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   // With LATENCY==1 the response is loaded on the accept edge itself, before the latches update.
   assign respWr  = accept ? wr         : wrLat;
   assign respErr = accept ? misaligned : errLat;
   assign rdIdx   = accept ? wordIdx    : idxLat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= 4'd0;
         wrLat    <= 1'b0;
         errLat   <= 1'b0;
         idxLat   <= '0;
         rdataReg <= 32'd0;
         errReg   <= 1'b0;
      end else begin
         cnt <= cntNext;
         if (accept) begin
            wrLat  <= wr;
            errLat <= misaligned;
            idxLat <= wordIdx;
         end
         if (nextState == RESP) begin
            rdataReg <= (respWr || respErr) ? 32'd0 : ramWord;
            errReg   <= respErr;
         end
      end
   end

   // Contents are deliberately not reset, so writes accepted before a reset survive it.
   for (genvar g = 0; g < 4; g++) begin : gLane
      logic [7:0] laneMem [DEPTH];

      always_ff @(posedge clk) begin
         if (accept && wr && strobe[g]) laneMem[wordIdx] <= wdata[8*g +: 8];
      end

      assign ramWord[8*g +: 8] = laneMem[rdIdx];
   end

   assign data_ok  = (state == RESP);
   assign rdata    = data_ok ? rdataReg : 32'd0;
   assign addr_err = data_ok & errReg;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Bench for dmem_sram_responder: one instance at LATENCY=2 and one at LATENCY=1, scoreboard-checked.
module tb_dmem_sram_responder;
   import mips_mem_pkg::*;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req     [2];
   logic        wr      [2];
   logic [1:0]  size    [2];
   logic [31:0] addr    [2];
   logic [31:0] wdata   [2];
   logic        addrOk  [2];
   logic        dataOk  [2];
   logic [31:0] rdata   [2];
   logic        addrErr [2];
   logic        busy    [2];

   exp_t sb0[$];
   exp_t sb1[$];
   exp_t monE;
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_sram_responder #(.ADDR_W(12), .LATENCY(2)) dutL2 (
      .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
      .wdata(wdata[0]), .addr_ok(addrOk[0]), .data_ok(dataOk[0]), .rdata(rdata[0]),
      .addr_err(addrErr[0]), .busy(busy[0])
   );

   dmem_sram_responder #(.ADDR_W(12), .LATENCY(1)) dutL1 (
      .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
      .wdata(wdata[1]), .addr_ok(addrOk[1]), .data_ok(dataOk[1]), .rdata(rdata[1]),
      .addr_err(addrErr[1]), .busy(busy[1])
   );

   // Response monitor: every data_ok pops the oldest expectation of that instance.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (dataOk[d] === 1'b1) begin
            checks++;
            if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
               errors++;
               $display("FAIL spurious_data_ok dut%0d: data_ok=1 at cycle %0d, required no response", d, cyc);
            end else begin
               if (d == 0) monE = sb0.pop_front();
               else        monE = sb1.pop_front();
               if (cyc !== monE.cyc) begin
                  errors++;
                  $display("FAIL resp_cycle dut%0d: got cycle %0d, required %0d", d, cyc, monE.cyc);
               end
               checks++;
               if (rdata[d] !== monE.data) begin
                  errors++;
                  $display("FAIL resp_rdata dut%0d: got %h, required %h", d, rdata[d], monE.data);
               end
               checks++;
               if (addrErr[d] !== monE.err) begin
                  errors++;
                  $display("FAIL resp_addr_err dut%0d: got %b, required %b", d, addrErr[d], monE.err);
               end
            end
         end
      end
   end

   // Called at a negedge; holds req until accepted, pushes the expected response, returns at a negedge.
   task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] expD, input logic expE,
                        output int waited);
      exp_t e;
      waited   = 0;
      req[d]   = 1'b1;
      wr[d]    = w;
      size[d]  = sz;
      addr[d]  = a;
      wdata[d] = wd;
      while (addrOk[d] !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (addrOk[d] !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout dut%0d addr=%h: addr_ok=%b after %0d cycles, required 1", d, a, addrOk[d], waited);
      end else begin
         e.cyc  = cyc + ((d == 0) ? 2 : 1);
         e.data = expD;
         e.err  = expE;
         if (d == 0) sb0.push_back(e);
         else        sb1.push_back(e);
      end
      @(negedge clk);
      req[d] = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((sb0.size() + sb1.size()) != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ((sb0.size() + sb1.size()) != 0) begin
         errors++;
         $display("FAIL drain_%s: %0d responses still pending, required 0", tag, sb0.size() + sb1.size());
      end
      sb0.delete();
      sb1.delete();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (addrOk[d] !== 1'b0) begin errors++; $display("FAIL reset_addr_ok dut%0d: got %b, required 0", d, addrOk[d]); end
         checks++;
         if (dataOk[d] !== 1'b0) begin errors++; $display("FAIL reset_data_ok dut%0d: got %b, required 0", d, dataOk[d]); end
         checks++;
         if (rdata[d] !== 32'd0) begin errors++; $display("FAIL reset_rdata dut%0d: got %h, required 0", d, rdata[d]); end
         checks++;
         if (addrErr[d] !== 1'b0) begin errors++; $display("FAIL reset_addr_err dut%0d: got %b, required 0", d, addrErr[d]); end
         checks++;
         if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b, required 0", d, busy[d]); end
      end
      rst = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (addrOk[d] !== 1'b1) begin errors++; $display("FAIL idle_addr_ok dut%0d: got %b, required 1", d, addrOk[d]); end
      end
   endtask

   task automatic test_word_rw();
      int w;
      issue(0, 1'b1, SIZE_WORD, 32'h100, 32'hDEADBEEF, 32'd0, 1'b0, w);
      issue(0, 1'b0, SIZE_WORD, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, w);
      checks++;
      if (w != 1) begin errors++; $display("FAIL l2_accept_spacing: waited %0d cycles, required 1", w); end
      wait_drain("word_rw");
   endtask

   task automatic test_byte_store();
      int w;
      issue(0, 1'b1, SIZE_WORD, 32'h100, 32'h11223344, 32'd0, 1'b0, w);
      issue(0, 1'b1, SIZE_BYTE, 32'h101, 32'h5A5A5A5A, 32'd0, 1'b0, w);
      issue(0, 1'b0, SIZE_WORD, 32'h100, 32'h0, 32'h11225A44, 1'b0, w);
      wait_drain("byte_store");
   endtask

   task automatic test_half_store();
      int w;
      issue(0, 1'b1, SIZE_HALF, 32'h102, 32'hBEEFBEEF, 32'd0, 1'b0, w);
      issue(0, 1'b0, SIZE_WORD, 32'h100, 32'h0, 32'hBEEF5A44, 1'b0, w);
      issue(0, 1'b1, SIZE_HALF, 32'h101, 32'h77777777, 32'd0, 1'b1, w);
      issue(0, 1'b0, SIZE_HALF, 32'h102, 32'h0, 32'hBEEF5A44, 1'b0, w);
      wait_drain("half_store");
   endtask

   task automatic test_illegal_alias();
      int w;
      issue(0, 1'b0, SIZE_ILLEGAL, 32'h0, 32'h0, 32'd0, 1'b1, w);
      issue(0, 1'b0, SIZE_WORD, 32'h102, 32'h0, 32'd0, 1'b1, w);
      issue(0, 1'b1, SIZE_WORD, 32'h4200, 32'hCAFEF00D, 32'd0, 1'b0, w);
      issue(0, 1'b0, SIZE_WORD, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0, w);
      issue(0, 1'b0, SIZE_BYTE, 32'hFFFF0203, 32'h0, 32'hCAFEF00D, 1'b0, w);
      wait_drain("illegal_alias");
   endtask

   task automatic test_reset_mid();
      int w;
      issue(0, 1'b1, SIZE_WORD, 32'h300, 32'h12345678, 32'd0, 1'b0, w);
      wait_drain("pre_reset");
      req[0] = 1'b1; wr[0] = 1'b1; size[0] = SIZE_WORD; addr[0] = 32'h304; wdata[0] = 32'hA5A5A5A5;
      checks++;
      if (addrOk[0] !== 1'b1) begin errors++; $display("FAIL mid_accept: addr_ok=%b, required 1", addrOk[0]); end
      @(negedge clk);
      req[0] = 1'b0;
      checks++;
      if (busy[0] !== 1'b1) begin errors++; $display("FAIL mid_busy_wait: got %b, required 1", busy[0]); end
      rst = 1'b0;
      #1;
      checks++;
      if (busy[0] !== 1'b0) begin errors++; $display("FAIL mid_busy_reset: got %b, required 0", busy[0]); end
      checks++;
      if (addrOk[0] !== 1'b0) begin errors++; $display("FAIL mid_addr_ok_reset: got %b, required 0", addrOk[0]); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (dataOk[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: data_ok=%b busy=%b, required 0 0", dataOk[0], busy[0]);
         end
      end
      issue(0, 1'b0, SIZE_WORD, 32'h300, 32'h0, 32'h12345678, 1'b0, w);
      issue(0, 1'b0, SIZE_WORD, 32'h304, 32'h0, 32'hA5A5A5A5, 1'b0, w);
      wait_drain("reset_mid");
   endtask

   task automatic test_back_to_back();
      int w;
      for (int i = 0; i < 4; i++) begin
         issue(1, 1'b1, SIZE_WORD, 32'h10 + 32'(4 * i), 32'hA0000000 + 32'(i), 32'd0, 1'b0, w);
      end
      for (int i = 0; i < 4; i++) begin
         issue(1, 1'b0, SIZE_WORD, 32'h10 + 32'(4 * i), 32'h0, 32'hA0000000 + 32'(i), 1'b0, w);
         checks++;
         if (w != 0) begin errors++; $display("FAIL l1_addr_ok_every_cycle read %0d: waited %0d, required 0", i, w); end
      end
      issue(1, 1'b1, SIZE_WORD, 32'h20, 32'h0BADF00D, 32'd0, 1'b0, w);
      issue(1, 1'b0, SIZE_WORD, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, w);
      checks++;
      if (w != 0) begin errors++; $display("FAIL l1_raw_accept: waited %0d, required 0", w); end
      wait_drain("back_to_back");
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (busy[d] !== 1'b0) begin errors++; $display("FAIL final_busy dut%0d: got %b, required 0", d, busy[d]); end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
      end
      test_reset();
      test_word_rw();
      test_byte_store();
      test_half_store();
      test_illegal_alias();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
